// File: rtl/sc64.sv
// rtl/sc64.sv - shared constants for the sc64 CPU-side bus
package sc64;

    localparam int          CPU_BUS_TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] CPU_BUS_ERROR_RDATA     = 32'hFFFF_FFFF;

endpackage

// File: rtl/cpu_bus_rr_picker.sv
// rtl/cpu_bus_rr_picker.sv - combinational round-robin pick starting after last_grant
module cpu_bus_rr_picker #(
    parameter int NUM_MASTERS = 2,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic [NUM_MASTERS-1:0] request,
    input  logic [GW-1:0]          last_grant,
    output logic                   valid,
    output logic [GW-1:0]          grant
);

    logic [GW-1:0] idx;

    // Walk from the lowest priority up so the nearest requester after last_grant is assigned last.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = GW'((int'(last_grant) + i) % NUM_MASTERS);
            if (request[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - round-robin sharer of the CPU bus master port with ack watchdog
module cpu_bus_arbiter
    import sc64::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = CPU_BUS_TIMEOUT_DEFAULT,
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_MASTERS-1:0]      m_request,
    input  logic [NUM_MASTERS-1:0][3:0] m_wmask,
    input  logic [NUM_MASTERS-1:0][31:0] m_address,
    input  logic [NUM_MASTERS-1:0][31:0] m_wdata,
    output logic [NUM_MASTERS-1:0]      m_ack,
    output logic [NUM_MASTERS-1:0]      m_error,
    output logic [31:0]                 m_rdata,
    output logic                        bus_request,
    output logic [3:0]                  bus_wmask,
    output logic [31:0]                 bus_address,
    output logic [31:0]                 bus_wdata,
    input  logic                        bus_ack,
    input  logic [31:0]                 bus_rdata,
    output logic                        timeout_flag,
    output logic [31:0]                 timeout_address,
    input  logic                        timeout_clear
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RELEASE
    } e_arbiter_state;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    e_arbiter_state state, next_state;
    logic [GW-1:0]  grant;
    logic [GW-1:0]  last_grant;
    logic [GW-1:0]  pick_grant;
    logic           pick_valid;
    logic [15:0]    counter;
    logic           timeout_hit;

    cpu_bus_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS)
    ) u_picker (
        .request    (m_request),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    assign timeout_hit = (counter == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (pick_valid) next_state = S_BUSY;
            S_BUSY:    if (bus_ack || timeout_hit) next_state = S_RELEASE;
            S_RELEASE: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus_request     <= 1'b0;
            bus_wmask       <= '0;
            bus_address     <= '0;
            bus_wdata       <= '0;
            m_ack           <= '0;
            m_error         <= '0;
            m_rdata         <= '0;
            timeout_flag    <= 1'b0;
            timeout_address <= '0;
            counter         <= '0;
            grant           <= '0;
            last_grant      <= GW'(NUM_MASTERS - 1);
        end else begin
            m_ack   <= '0;
            m_error <= '0;
            if (timeout_clear) begin
                timeout_flag <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        bus_request <= 1'b1;
                        bus_wmask   <= m_wmask[pick_grant];
                        bus_address <= m_address[pick_grant];
                        bus_wdata   <= m_wdata[pick_grant];
                        counter     <= '0;
                        grant       <= pick_grant;
                    end
                end
                S_BUSY: begin
                    // An ack in the final watchdog cycle still completes normally.
                    if (bus_ack) begin
                        m_rdata      <= bus_rdata;
                        m_ack[grant] <= 1'b1;
                        bus_request  <= 1'b0;
                        last_grant   <= grant;
                    end else if (timeout_hit) begin
                        m_rdata         <= CPU_BUS_ERROR_RDATA;
                        m_ack[grant]    <= 1'b1;
                        m_error[grant]  <= 1'b1;
                        bus_request     <= 1'b0;
                        timeout_flag    <= 1'b1;
                        timeout_address <= bus_address;
                    end else if (counter != 16'hFFFF) begin
                        counter <= counter + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - directed scoreboard bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;

    logic             clk;
    logic             reset;
    logic [1:0]       m_request;
    logic [1:0][3:0]  m_wmask;
    logic [1:0][31:0] m_address;
    logic [1:0][31:0] m_wdata;
    logic [1:0]       m_ack;
    logic [1:0]       m_error;
    logic [31:0]      m_rdata;
    logic             bus_request;
    logic [3:0]       bus_wmask;
    logic [31:0]      bus_address;
    logic [31:0]      bus_wdata;
    logic             bus_ack;
    logic [31:0]      bus_rdata;
    logic             timeout_flag;
    logic [31:0]      timeout_address;
    logic             timeout_clear;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    cpu_bus_arbiter #(
        .NUM_MASTERS    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .m_request       (m_request),
        .m_wmask         (m_wmask),
        .m_address       (m_address),
        .m_wdata         (m_wdata),
        .m_ack           (m_ack),
        .m_error         (m_error),
        .m_rdata         (m_rdata),
        .bus_request     (bus_request),
        .bus_wmask       (bus_wmask),
        .bus_address     (bus_address),
        .bus_wdata       (bus_wdata),
        .bus_ack         (bus_ack),
        .bus_rdata       (bus_rdata),
        .timeout_flag    (timeout_flag),
        .timeout_address (timeout_address),
        .timeout_clear   (timeout_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Wait for the grant, confirm it went to exp_m, then ack after delay cycles.
    task automatic serve(input int exp_m, input logic [31:0] exp_addr, input logic [31:0] rdata,
                         input int delay, output int waited);
        waited = 0;
        while (!bus_request && waited < 20) begin
            tick();
            waited++;
        end
        check("grant_bus_request", 32'(bus_request), 32'd1);
        check("grant_address", bus_address, exp_addr);
        repeat (delay) tick();
        bus_ack   = 1'b1;
        bus_rdata = rdata;
        sb.push_back('{m: exp_m, rdata: rdata, err: 1'b0});
        tick();
        bus_ack   = 1'b0;
        bus_rdata = '0;
    endtask

    always @(negedge clk) begin
        if (m_ack != 2'b00) begin
            n_checks++;
            assert (sb.size() > 0) n_pass++;
            else $error("FAIL sb_unexpected_ack observed=%b expected=none", m_ack);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("sb_ack_onehot", 32'(m_ack), 32'(1) << e.m);
                check("sb_error", 32'(m_error), e.err ? (32'(1) << e.m) : 32'd0);
                check("sb_rdata", m_rdata, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        int w;
        int hi;
        reset         = 1'b1;
        m_request     = '0;
        m_wmask       = '0;
        m_address     = '0;
        m_wdata       = '0;
        bus_ack       = 1'b0;
        bus_rdata     = '0;
        timeout_clear = 1'b0;
        tick();
        tick();
        check("rst_bus_request", 32'(bus_request), 32'd0);
        check("rst_bus_address", bus_address, 32'd0);
        check("rst_m_ack", 32'(m_ack), 32'd0);
        check("rst_m_rdata", m_rdata, 32'd0);
        check("rst_timeout_flag", 32'(timeout_flag), 32'd0);
        check("rst_timeout_address", timeout_address, 32'd0);
        reset = 1'b0;

        // single read, ack one cycle after bus_request
        m_address[0] = 32'h1000_0004;
        m_request    = 2'b01;
        tick();
        check("t1_bus_request_n1", 32'(bus_request), 32'd1);
        check("t1_bus_address", bus_address, 32'h1000_0004);
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_0001;
        sb.push_back('{m: 0, rdata: 32'hCAFE_0001, err: 1'b0});
        tick();
        bus_ack   = 1'b0;
        bus_rdata = '0;
        check("t1_m_ack_n2", 32'(m_ack), 32'd1);
        check("t1_m_error", 32'(m_error), 32'd0);
        m_request = 2'b00;
        tick();
        check("t1_release_n3", 32'(bus_request), 32'd0);
        tick();

        // round robin with both masters requesting
        pulse_reset();
        m_address[0] = 32'h1000_0100;
        m_address[1] = 32'h2000_0200;
        m_request    = 2'b11;
        for (int k = 0; k < 6; k++) begin
            serve(k % 2, m_address[k % 2], 32'hA000_0000 + 32'(k), k % 3, w);
            if (k > 0) check("rr_gap", 32'(w <= 2), 32'd1);
        end
        m_request = 2'b00;
        tick();
        tick();

        // watchdog termination
        m_address[0] = 32'hF000_0000;
        m_request    = 2'b01;
        sb.push_back('{m: 0, rdata: 32'hFFFF_FFFF, err: 1'b1});
        tick();
        hi = 0;
        while (bus_request && hi < 20) begin
            hi++;
            tick();
        end
        check("to_request_cycles", 32'(hi), 32'd8);
        check("to_m_ack", 32'(m_ack), 32'd1);
        check("to_m_error", 32'(m_error), 32'd1);
        check("to_flag", 32'(timeout_flag), 32'd1);
        check("to_address", timeout_address, 32'hF000_0000);
        m_request     = 2'b00;
        timeout_clear = 1'b1;
        tick();
        timeout_clear = 1'b0;
        check("to_clear_flag", 32'(timeout_flag), 32'd0);
        check("to_clear_address", timeout_address, 32'hF000_0000);

        // write whose inputs change mid-access
        m_address[0] = 32'h1000_0010;
        m_wdata[0]   = 32'h1234_5678;
        m_wmask[0]   = 4'b0011;
        m_request    = 2'b01;
        tick();
        m_address[0] = 32'h3000_0000;
        m_wdata[0]   = 32'hDEAD_BEEF;
        m_wmask[0]   = 4'b1111;
        tick();
        tick();
        check("wr_hold_address", bus_address, 32'h1000_0010);
        check("wr_hold_wdata", bus_wdata, 32'h1234_5678);
        check("wr_hold_wmask", 32'(bus_wmask), 32'h3);
        bus_ack = 1'b1;
        sb.push_back('{m: 0, rdata: 32'h0, err: 1'b0});
        tick();
        bus_ack = 1'b0;
        check("wr_m_ack", 32'(m_ack), 32'd1);
        m_request  = 2'b00;
        m_wmask[0] = 4'b0000;
        tick();
        tick();

        // reset in the third busy cycle, then master 0 must win
        m_address[0] = 32'h1000_0020;
        m_request    = 2'b01;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_bus_request", 32'(bus_request), 32'd0);
        check("rst_mid_m_ack", 32'(m_ack), 32'd0);
        m_address[1] = 32'h2000_0020;
        m_request    = 2'b11;
        reset        = 1'b0;
        serve(0, 32'h1000_0020, 32'hBEEF_0005, 1, w);
        m_request = 2'b00;
        tick();
        tick();

        // ack in the exact watchdog cycle
        m_address[1] = 32'h2000_0300;
        m_request    = 2'b10;
        tick();
        repeat (7) tick();
        check("edge_still_busy", 32'(bus_request), 32'd1);
        bus_ack   = 1'b1;
        bus_rdata = 32'h5555_AAAA;
        sb.push_back('{m: 1, rdata: 32'h5555_AAAA, err: 1'b0});
        tick();
        bus_ack   = 1'b0;
        bus_rdata = '0;
        check("edge_m_ack", 32'(m_ack), 32'd2);
        check("edge_m_error", 32'(m_error), 32'd0);
        check("edge_flag", 32'(timeout_flag), 32'd0);
        m_request = 2'b00;
        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
